// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one millisecond down-count timer to NUM_REQ requesters.
// Optional `TIMER_ARB_PAUSE_EN adds a pause input that freezes the running countdown.
module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_MS  = 1000,
  parameter int TW      = $clog2(MAX_MS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*TW-1:0] req_ms,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic                  tmr_reset,
  output logic                  tmr_up,
  output logic                  tmr_enable,
  output logic [TW-1:0]         tmr_start_value,
  input  logic                  tmr_expire
`ifdef TIMER_ARB_PAUSE_EN
  ,
  input  logic                  pause
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [TW-1:0]        cnt_q, cnt_d;

  logic [IW-1:0]        cand_idx [NUM_REQ];
  logic [TW-1:0]        ms_arr   [NUM_REQ];
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic [TW-1:0]        ms_sel;
  logic [IW-1:0]        next_ptr;
  logic                 pause_w;

`ifdef TIMER_ARB_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // cand_idx[k] is the k-th requester examined, starting at the rr pointer
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign cand_idx[gi] = IW'((int'(ptr_q) + gi) % NUM_REQ);
    assign ms_arr[gi]   = req_ms[gi*TW +: TW];
  end

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign ms_sel   = ms_arr[pick_idx];
  assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= TW'(1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_LOAD;
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          cnt_d   = (ms_sel == '0) ? TW'(1) : ms_sel;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // Expiry beats a simultaneous request drop; expiry while paused is ignored
        if (tmr_expire && !pause_w) begin
          state_d = S_DONE;
        end else if (!req[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = next_ptr;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant           = grant_q;
    done            = '0;
    busy            = (state_q != S_IDLE);
    tmr_reset       = 1'b1;
    tmr_enable      = 1'b0;
    tmr_up          = 1'b0;
    tmr_start_value = cnt_q - 1'b1;
    case (state_q)
      S_RUN: begin
        tmr_reset  = 1'b0;
        tmr_enable = !pause_w;
      end
      S_DONE:  done = grant_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: millisecond timer stub, cycle-level reference model and directed scenarios.
// Define TIMER_ARB_PAUSE_EN to also exercise the pause input.
module tb_timer_arbiter;
  localparam int N      = 4;
  localparam int MAX_MS = 1000;
  localparam int TW     = $clog2(MAX_MS);
  localparam int CPM    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [TW-1:0]     ms [N];
  logic [N*TW-1:0]   req_ms;
  logic [N-1:0]      grant, done;
  logic              busy, tmr_reset, tmr_up, tmr_enable, tmr_expire;
  logic [TW-1:0]     tmr_start_value;
  logic              pause = 1'b0;
  logic              exp_inj = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_ms = '0;
    for (int i = 0; i < N; i++) req_ms[i*TW +: TW] = ms[i];
  end

  // Timer stub: loads start_value under reset, ticks every CPM enabled clocks, pulses on rollover
  logic [TW-1:0] t_val;
  int            t_pre;
  logic          t_exp;
  always @(posedge clk) begin
    if (tmr_reset) begin
      t_val <= tmr_start_value;
      t_pre <= 0;
      t_exp <= 1'b0;
    end else if (tmr_enable) begin
      if (t_pre == CPM - 1) begin
        t_pre <= 0;
        if (t_val == '0) begin
          t_val <= TW'(MAX_MS - 1);
          t_exp <= 1'b1;
        end else begin
          t_val <= t_val - 1'b1;
          t_exp <= 1'b0;
        end
      end else begin
        t_pre <= t_pre + 1;
        t_exp <= 1'b0;
      end
    end else begin
      t_exp <= 1'b0;
    end
  end
  assign tmr_expire = t_exp | exp_inj;

  timer_arbiter #(.NUM_REQ(N), .MAX_MS(MAX_MS)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ms(req_ms),
    .grant(grant), .done(done), .busy(busy),
    .tmr_reset(tmr_reset), .tmr_up(tmr_up), .tmr_enable(tmr_enable),
    .tmr_start_value(tmr_start_value), .tmr_expire(tmr_expire)
`ifdef TIMER_ARB_PAUSE_EN
    , .pause(pause)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ownership has a LOAD cycle (off 0), RUN cycles and a DONE cycle at
  // off == dur, where dur = CPM*ms + 2; each paused RUN cycle pushes DONE out by one.
  bit        m_busy = 1'b0;
  logic [1:0] m_own = '0;
  logic [1:0] m_ptr = '0;
  int        m_cnt = 1, m_off = 0, m_dur = 0;
  int        cyc = 0, load_cyc = 0, done_cyc = 0, ld_sv = 0, ndone = 0;
  int        glog[$];
  int        dlog[$];
  logic [N-1:0] prev_grant = '0;

  initial begin
    bit         run, found;
    logic [1:0] c;
    int         e_grant;
    forever begin
      @(negedge clk);
      cyc++;
      run     = m_busy && (m_off > 0) && (m_off < m_dur);
      e_grant = m_busy ? int'(4'b0001 << m_own) : 0;
      chk("cyc_grant",  int'(grant), e_grant);
      chk("cyc_done",   int'(done), (m_busy && m_off == m_dur) ? e_grant : 0);
      chk("cyc_busy",   int'(busy), int'(m_busy));
      chk("cyc_treset", int'(tmr_reset), int'(!run));
      chk("cyc_enable", int'(tmr_enable), int'(run && !pause));
      chk("cyc_sv",     int'(tmr_start_value), m_cnt - 1);
      chk("cyc_up",     int'(tmr_up), 0);

      if (grant != '0 && prev_grant == '0) begin
        load_cyc = cyc;
        ld_sv    = int'(tmr_start_value);
        glog.push_back(int'(grant));
      end
      if (done != '0) begin
        done_cyc = cyc;
        dlog.push_back(int'(done));
        ndone++;
      end
      prev_grant = grant;

      if (reset) begin
        m_busy = 1'b0;
        m_ptr  = '0;
        m_cnt  = 1;
      end else if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = m_ptr + 2'(k);
          if (!found && req[c]) begin
            found = 1'b1;
            m_own = c;
          end
        end
        if (found) begin
          m_busy = 1'b1;
          m_cnt  = (ms[m_own] == '0) ? 1 : int'(ms[m_own]);
          m_off  = 0;
          m_dur  = CPM * m_cnt + 2;
        end
      end else if (m_off == 0) begin
        m_off = 1;
      end else if (m_off == m_dur) begin
        m_ptr  = m_own + 2'd1;
        m_busy = 1'b0;
      end else if (!pause && m_off == m_dur - 1) begin
        m_off++;
      end else if (!req[m_own]) begin
        m_ptr  = m_own + 2'd1;
        m_busy = 1'b0;
      end else begin
        if (pause) m_dur++;
        m_off++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc);
    int start, k;
    start = ndone;
    k = 0;
    while (ndone == start && k < maxc) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (ndone == start) chk("done_timeout", 0, 1);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    for (int i = 0; i < N; i++) ms[i] = '0;
    tick(3);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_treset", int'(tmr_reset), 1);
    chk("rst_sv", int'(tmr_start_value), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    tick(2);

    // 1: single 3 ms request; spurious expire in IDLE and LOAD must be ignored
    ms[0] = TW'(3); req = 4'b0001; exp_inj = 1'b1;
    tick(1);
    chk("t1_grant", int'(grant), 1);
    chk("t1_load_sv", int'(tmr_start_value), 2);
    tick(1);
    exp_inj = 1'b0;
    chk("t1_enable", int'(tmr_enable), 1);
    wait_done(200);
    chk("t1_latency", done_cyc - load_cyc, 14);
    chk("t1_done_val", qget(dlog, dlog.size() - 1), 1);
    req = '0;
    tick(1);
    chk("t1_grant_clr", int'(grant), 0);
    $display("[TB] t1 single request: latency %0d", done_cyc - load_cyc);

    // 2: round robin over 1011
    reset = 1'b1; tick(2); reset = 1'b0;
    glog.delete(); dlog.delete();
    for (int i = 0; i < N; i++) ms[i] = TW'(2);
    req = 4'b1011;
    repeat (4) wait_done(200);
    req = '0;
    tick(2);
    chk("t2_ngrant", glog.size(), 4);
    chk("t2_g0", qget(glog, 0), 1);
    chk("t2_g1", qget(glog, 1), 2);
    chk("t2_g2", qget(glog, 2), 8);
    chk("t2_g3", qget(glog, 3), 1);
    chk("t2_d2", qget(dlog, 2), 8);
    $display("[TB] t2 round robin: %0d grants", glog.size());

    // 3: owner 2 drops mid-run, pending 3 takes over
    reset = 1'b1; tick(2); reset = 1'b0;
    glog.delete(); dlog.delete();
    ms[2] = TW'(5); ms[3] = TW'(2);
    req = 4'b1100;
    tick(8);
    chk("t3_owner", int'(grant), 4);
    req = 4'b1000;
    tick(1);
    chk("t3_abort_en", int'(tmr_enable), 0);
    chk("t3_abort_busy", int'(busy), 0);
    tick(1);
    chk("t3_next_grant", int'(grant), 8);
    wait_done(200);
    req = '0;
    tick(1);
    chk("t3_ndone", dlog.size(), 1);
    chk("t3_done_val", qget(dlog, 0), 8);
    $display("[TB] t3 abort: next grant %0d", qget(glog, 1));

    // 4: zero duration and maximum duration
    ms[0] = '0; req = 4'b0001;
    wait_done(200);
    req = '0;
    chk("t4_zero_sv", ld_sv, 0);
    chk("t4_zero_latency", done_cyc - load_cyc, 6);
    tick(1);
    ms[0] = TW'(MAX_MS - 1); req = 4'b0001;
    wait_done(5000);
    req = '0;
    chk("t4_max_sv", ld_sv, 998);
    chk("t4_max_latency", done_cyc - load_cyc, 3998);
    tick(1);
    $display("[TB] t4 bounds: max latency %0d", done_cyc - load_cyc);

    // 5: reset during RUN
    ms[1] = TW'(5); req = 4'b0010;
    tick(6);
    chk("t5_running", int'(tmr_enable), 1);
    reset = 1'b1;
    tick(1);
    chk("t5_grant", int'(grant), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_treset", int'(tmr_reset), 1);
    chk("t5_done", int'(done), 0);
    reset = 1'b0; req = '0;
    tick(2);
    exp_inj = 1'b1;
    tick(2);
    exp_inj = 1'b0;
    chk("t5_idle_expire", int'(busy), 0);
    $display("[TB] t5 reset mid-run done");

`ifdef TIMER_ARB_PAUSE_EN
    // 6: 2 ms pause inside a 5 ms run
    ms[0] = TW'(5); req = 4'b0001;
    tick(6);
    pause = 1'b1;
    tick(4);
    chk("t6_paused_en", int'(tmr_enable), 0);
    tick(4);
    pause = 1'b0;
    wait_done(200);
    req = '0;
    chk("t6_latency", done_cyc - load_cyc, 30);
    tick(2);
    $display("[TB] t6 pause: latency %0d", done_cyc - load_cyc);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
